// File: rtl/icache_dm_rv32.sv
// rtl/icache_dm_rv32.sv - direct-mapped multi-word-line RV32I instruction cache
module icache_dm_rv32 #(
    parameter int NLINES = 16,
    parameter int WPL    = 4
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic        iREQ,
    input  logic [31:0] iPCADDR,
    input  logic        iFLUSH,
    output logic [31:0] oPCDATA,
    output logic        oVALID,
    output logic        oStallI,
    output logic        oMEMREQ,
    output logic [31:0] oMEMADDR,
    input  logic [31:0] iMEMDATA,
    input  logic        iMEMRDY
);
    localparam int OFFW = $clog2(WPL);
    localparam int IDXW = $clog2(NLINES);
    localparam int TAGW = 30 - OFFW - IDXW;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP} state_t;

    state_t            r_state, w_state_nx;
    logic [31:2]       r_addr, w_addr_nx;
    logic [OFFW-1:0]   r_cnt, w_cnt_nx;
    logic              r_flush_pend, w_flush_pend_nx;
    logic [NLINES-1:0] r_valid, w_valid_nx;
    logic [31:0]       r_pcdata, w_pcdata_nx;
    logic              r_ovalid, w_ovalid_nx;
    logic              r_stall, w_stall_nx;
    logic              r_memreq, w_memreq_nx;
    logic [31:0]       r_memaddr, w_memaddr_nx;

    logic [TAGW-1:0]   r_tag  [NLINES];
    logic [31:0]       r_data [NLINES*WPL];

    logic [TAGW-1:0]   w_req_tag, w_lat_tag;
    logic [IDXW-1:0]   w_req_idx, w_lat_idx;
    logic [OFFW-1:0]   w_req_off, w_lat_off;
    logic              w_hit, w_wr_en, w_last;
    logic              w_unused;

    assign w_req_tag = iPCADDR[31 -: TAGW];
    assign w_req_idx = iPCADDR[2+OFFW +: IDXW];
    assign w_req_off = iPCADDR[2 +: OFFW];
    assign w_lat_tag = r_addr[31 -: TAGW];
    assign w_lat_idx = r_addr[2+OFFW +: IDXW];
    assign w_lat_off = r_addr[2 +: OFFW];
    assign w_unused  = &{1'b0, iPCADDR[1:0]};

    // A simultaneous flush must not let a stale line hit
    assign w_hit   = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag) && !iFLUSH;
    assign w_wr_en = (r_state == S_REFILL) && iMEMRDY;
    assign w_last  = w_wr_en && (r_cnt == OFFW'(WPL-1));

    always_comb begin
        w_state_nx      = r_state;
        w_addr_nx       = r_addr;
        w_cnt_nx        = r_cnt;
        w_flush_pend_nx = r_flush_pend;
        w_valid_nx      = r_valid;
        w_pcdata_nx     = r_pcdata;
        w_ovalid_nx     = 1'b0;
        w_stall_nx      = r_stall;
        w_memreq_nx     = r_memreq;
        w_memaddr_nx    = r_memaddr;
        case (r_state)
            S_IDLE: begin
                if (iFLUSH) w_valid_nx = '0;
                if (iREQ) begin
                    if (w_hit) begin
                        w_pcdata_nx = r_data[{w_req_idx, w_req_off}];
                        w_ovalid_nx = 1'b1;
                    end else begin
                        w_addr_nx    = iPCADDR[31:2];
                        w_stall_nx   = 1'b1;
                        w_memreq_nx  = 1'b1;
                        w_memaddr_nx = {iPCADDR[31:2+OFFW], {OFFW{1'b0}}, 2'b00};
                        w_cnt_nx     = '0;
                        w_state_nx   = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                if (iFLUSH) begin
                    w_valid_nx      = '0;
                    w_flush_pend_nx = 1'b1;
                end
                if (iMEMRDY) begin
                    w_cnt_nx     = r_cnt + 1'b1;
                    w_memaddr_nx = r_memaddr + 32'd4;
                    if (w_last) begin
                        w_valid_nx[w_lat_idx] = ~(r_flush_pend | iFLUSH);
                        w_memreq_nx = 1'b0;
                        w_state_nx  = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (iFLUSH) w_valid_nx = '0;
                w_pcdata_nx     = r_data[{w_lat_idx, w_lat_off}];
                w_ovalid_nx     = 1'b1;
                w_stall_nx      = 1'b0;
                w_flush_pend_nx = 1'b0;
                w_state_nx      = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_valid      <= '0;
            r_pcdata     <= '0;
            r_ovalid     <= 1'b0;
            r_stall      <= 1'b0;
            r_memreq     <= 1'b0;
            r_memaddr    <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_addr       <= w_addr_nx;
            r_cnt        <= w_cnt_nx;
            r_flush_pend <= w_flush_pend_nx;
            r_valid      <= w_valid_nx;
            r_pcdata     <= w_pcdata_nx;
            r_ovalid     <= w_ovalid_nx;
            r_stall      <= w_stall_nx;
            r_memreq     <= w_memreq_nx;
            r_memaddr    <= w_memaddr_nx;
        end
    end

    // Storage arrays are deliberately left unreset; valid bits guard them
    always_ff @(posedge iCLK) begin
        if (w_wr_en) r_data[{w_lat_idx, r_cnt}] <= iMEMDATA;
        if (w_last)  r_tag[w_lat_idx] <= w_lat_tag;
    end

    assign oPCDATA  = r_pcdata;
    assign oVALID   = r_ovalid;
    assign oStallI  = r_stall;
    assign oMEMREQ  = r_memreq;
    assign oMEMADDR = r_memaddr;
endmodule

// File: tb/tb_icache_dm_rv32.sv
// tb/tb_icache_dm_rv32.sv - directed table-driven bench for icache_dm_rv32
module tb_icache_dm_rv32;
    logic        iCLK = 1'b0;
    logic        iRSTn;
    logic        iREQ;
    logic [31:0] iPCADDR;
    logic        iFLUSH;
    logic [31:0] oPCDATA;
    logic        oVALID;
    logic        oStallI;
    logic        oMEMREQ;
    logic [31:0] oMEMADDR;
    logic [31:0] iMEMDATA;
    logic        iMEMRDY;

    int total = 0;
    int bad   = 0;

    always #5 iCLK = ~iCLK;

    icache_dm_rv32 #(.NLINES(16), .WPL(4)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iREQ(iREQ), .iPCADDR(iPCADDR), .iFLUSH(iFLUSH),
        .oPCDATA(oPCDATA), .oVALID(oVALID), .oStallI(oStallI), .oMEMREQ(oMEMREQ),
        .oMEMADDR(oMEMADDR), .iMEMDATA(iMEMDATA), .iMEMRDY(iMEMRDY)
    );

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign iMEMDATA = memval(oMEMADDR);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          toggle;
        int          flush_at;
        int          exp_lat;
        int          exp_beats;
        logic [31:0] exp_base;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(input vec_t v, input int id);
        int          cyc;
        logic [31:0] beats[$];
        bit          stall_ok, got, rdy;
        logic [31:0] data;
        logic        stall_at_v;
        cyc = 0; got = 0; stall_ok = 1; data = '0; stall_at_v = 1'b1;
        @(negedge iCLK);
        iREQ = 1'b1; iPCADDR = v.addr; iFLUSH = (v.flush_at == 0); iMEMRDY = 1'b0;
        while (cyc < 40 && !got) begin
            @(negedge iCLK);
            cyc++;
            iREQ = 1'b0;
            iFLUSH = (v.flush_at == cyc);
            if (oVALID) begin
                got = 1; data = oPCDATA; stall_at_v = oStallI;
            end else begin
                if (!oStallI) stall_ok = 0;
                rdy = v.toggle ? (cyc % 2 == 1) : 1'b1;
                if (oMEMREQ && rdy) beats.push_back(oMEMADDR);
                iMEMRDY = rdy;
            end
        end
        iFLUSH = 1'b0; iMEMRDY = 1'b0;
        chk($sformatf("v%0d got_valid", id), 32'(got), 32'd1);
        chk($sformatf("v%0d latency", id), 32'(cyc), 32'(v.exp_lat));
        chk($sformatf("v%0d data", id), data, memval(v.addr));
        chk($sformatf("v%0d stall_at_valid", id), 32'(stall_at_v), 32'd0);
        chk($sformatf("v%0d stall_held", id), 32'(stall_ok), 32'd1);
        chk($sformatf("v%0d nbeats", id), 32'(beats.size()), 32'(v.exp_beats));
        foreach (beats[k])
            chk($sformatf("v%0d beat%0d addr", id, k), beats[k], v.exp_base + 32'(4*k));
    endtask

    task automatic b2b_hits();
        logic [31:0] a[3];
        a[0] = 32'h104; a[1] = 32'h108; a[2] = 32'h10C;
        @(negedge iCLK);
        iREQ = 1'b1; iPCADDR = a[0];
        for (int k = 0; k < 3; k++) begin
            @(negedge iCLK);
            chk($sformatf("b2b%0d valid", k), 32'(oVALID), 32'd1);
            chk($sformatf("b2b%0d data", k), oPCDATA, memval(a[k]));
            chk($sformatf("b2b%0d memreq", k), 32'(oMEMREQ), 32'd0);
            if (k < 2) iPCADDR = a[k+1];
            else iREQ = 1'b0;
        end
        @(negedge iCLK);
        chk("b2b valid_pulse_end", 32'(oVALID), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h100, 1'b0, -1, 6, 4, 32'h100};
        vecs[1]  = '{32'h200, 1'b0, -1, 6, 4, 32'h200};
        vecs[2]  = '{32'h100, 1'b0, -1, 6, 4, 32'h100};
        vecs[3]  = '{32'h10C, 1'b0, -1, 1, 0, 32'h0};
        vecs[4]  = '{32'h148, 1'b1, -1, 9, 4, 32'h140};
        vecs[5]  = '{32'h144, 1'b0, -1, 1, 0, 32'h0};
        vecs[6]  = '{32'h30C, 1'b0,  3, 6, 4, 32'h300};
        vecs[7]  = '{32'h300, 1'b0, -1, 6, 4, 32'h300};
        vecs[8]  = '{32'h144, 1'b0, -1, 6, 4, 32'h140};
        vecs[9]  = '{32'h304, 1'b0, -1, 1, 0, 32'h0};
        vecs[10] = '{32'h308, 1'b0,  0, 6, 4, 32'h300};
        vecs[11] = '{32'h308, 1'b0, -1, 1, 0, 32'h0};

        iRSTn = 1'b0; iREQ = 1'b0; iPCADDR = '0; iFLUSH = 1'b0; iMEMRDY = 1'b0;
        repeat (2) @(negedge iCLK);
        chk("rst pcdata", oPCDATA, 32'h0);
        chk("rst valid", 32'(oVALID), 32'd0);
        chk("rst stall", 32'(oStallI), 32'd0);
        chk("rst memreq", 32'(oMEMREQ), 32'd0);
        chk("rst memaddr", oMEMADDR, 32'h0);
        iRSTn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
            if (i == 0) b2b_hits();
        end

        // reset in the middle of a refill burst
        @(negedge iCLK);
        iREQ = 1'b1; iPCADDR = 32'h100; iMEMRDY = 1'b1;
        @(negedge iCLK);
        iREQ = 1'b0;
        @(negedge iCLK);
        chk("midrst memreq_before", 32'(oMEMREQ), 32'd1);
        #2 iRSTn = 1'b0;
        #1;
        chk("midrst memreq", 32'(oMEMREQ), 32'd0);
        chk("midrst stall", 32'(oStallI), 32'd0);
        chk("midrst valid", 32'(oVALID), 32'd0);
        @(negedge iCLK);
        iRSTn = 1'b1; iMEMRDY = 1'b0;
        run_vec('{32'h100, 1'b0, -1, 6, 4, 32'h100}, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
